// File: rtl/serial_subtractor_if.sv
// Request/response bundle between a client and the bit-serial subtract engine.
// Latency: none, this is wiring only.
// Backpressure: start_valid/start_ready on the request side, done_valid/done_ready on the result side.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             done_valid;
  logic             done_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;

  // Client side: issues operands, consumes results.
  modport master (
    output start_valid, a, b, bin, done_ready,
    input  start_ready, done_valid, diff, bout, zero
  );

  // Engine side: accepts operands, presents results.
  modport slave (
    input  start_valid, a, b, bin, done_ready,
    output start_ready, done_valid, diff, bout, zero
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Latency: request accepted at edge E, result valid after edge E+WIDTH; issue interval WIDTH+2.
// Backpressure: result held in DONE until done_ready; no new request is taken until then.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic             borrow;
  logic [CW-1:0]    cnt;
  // Holds the WIDTH-1 bits already produced; the final bit joins at the MSB
  // on the last BUSY cycle, so no extra cycle is spent assembling the result.
  logic [WIDTH-2:0] res;

  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             zero_q;

  logic             start_ready;
  logic             done_valid;
  logic             accept;
  logic             last;
  logic             x;
  logic             y;
  logic             d;
  logic             br_next;
  logic [WIDTH-1:0] res_final;

  // Single full-subtractor cell working on the current operand LSBs.
  always_comb begin
    x         = sh_a[0];
    y         = sh_b[0];
    d         = x ^ y ^ borrow;
    br_next   = (~x & y) | (~(x ^ y) & borrow);
    res_final = {d, res};
    last      = (cnt == CW'(WIDTH - 1));
    accept    = bus.start_valid & start_ready;
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt   = state;
    start_ready = 1'b0;
    done_valid  = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (bus.start_valid) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done_valid = 1'b1;
        if (bus.done_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand shifters, borrow, bit counter and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_a   <= '0;
      sh_b   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      res    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      zero_q <= 1'b0;
    end else if (state == IDLE) begin
      if (accept) begin
        sh_a   <= bus.a;
        sh_b   <= bus.b;
        borrow <= bus.bin;
        cnt    <= '0;
      end
    end else if (state == BUSY) begin
      sh_a   <= sh_a >> 1;
      sh_b   <= sh_b >> 1;
      borrow <= br_next;
      res    <= res_final[WIDTH-1:1];
      if (last) begin
        // Counter parks at WIDTH-1 instead of wrapping; IDLE reloads it.
        diff_q <= res_final;
        bout_q <= br_next;
        zero_q <= (res_final == '0);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign bus.start_ready = start_ready;
  assign bus.done_valid  = done_valid;
  assign bus.diff        = diff_q;
  assign bus.bout        = bout_q;
  assign bus.zero        = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): directed vectors plus random traffic.
// Latency: results are matched in order against a queue filled at each accept edge.
// Backpressure: done_ready is held high, held low, or randomised by a dedicated process.
module tb_serial_subtractor;

  logic clk;
  logic rst_n;

  serial_subtractor_if #(.WIDTH(8)) bus();

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         n_checks;
  int         n_errors;
  int         n_push;
  int         n_pop;
  int         rdy_mode;   // 0: always ready, 1: random, 2: never ready
  logic [9:0] exp_q[$];   // {bout, diff, zero}

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb, input logic mbin);
    logic [8:0] r;
    r = {1'b0, ma} - {1'b0, mb} - {8'b0, mbin};
    return {r[8], r[7:0], (r[7:0] == 8'h00)};
  endfunction

  // Consumer readiness, updated just after each rising edge.
  initial begin
    bus.done_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.done_ready = 1'b1;
        1:       bus.done_ready = 1'($urandom_range(0, 1));
        default: bus.done_ready = 1'b0;
      endcase
    end
  end

  // Monitor: every completed result handshake pops and compares one entry.
  always @(negedge clk) begin
    if (rst_n && bus.done_valid && bus.done_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {22'b0, bus.bout, bus.diff, bus.zero}, 32'hFFFF_FFFF);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        n_pop++;
        check("result", {22'b0, bus.bout, bus.diff, bus.zero}, {22'b0, e});
      end
    end
  end

  // Present a request and hold it until accepted; queue its expected result.
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                       input logic [9:0] exp, input bit push);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    bus.start_valid = 1'b1;
    bus.a           = ia;
    bus.b           = ib;
    bus.bin         = ibin;
    @(negedge clk);
    while (!bus.start_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.start_ready) timeout("accept_wait");
    @(posedge clk);
    if (push) begin
      exp_q.push_back(exp);
      n_push++;
    end
    #1;
    bus.start_valid = 1'b0;
  endtask

  task automatic drain;
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || !bus.start_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || !bus.start_ready) timeout("drain_wait");
  endtask

  // Directed and random stimulus.
  initial begin
    n_checks        = 0;
    n_errors        = 0;
    n_push          = 0;
    n_pop           = 0;
    rdy_mode        = 0;
    rst_n           = 1'b0;
    bus.start_valid = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.bin         = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_start_ready", 32'(bus.start_ready), 32'd1);
    check("rst_done_valid",  32'(bus.done_valid),  32'd0);
    check("rst_diff",        32'(bus.diff),        32'd0);
    check("rst_bout",        32'(bus.bout),        32'd0);
    check("rst_zero",        32'(bus.zero),        32'd0);

    // Basic subtract and its exact latency.
    issue(8'h35, 8'h12, 1'b0, {1'b0, 8'h23, 1'b0}, 1'b1);
    repeat (7) @(posedge clk);
    #1;
    check("latency_e7_not_done", 32'(bus.done_valid), 32'd0);
    @(posedge clk);
    #1;
    check("latency_e8_done", 32'(bus.done_valid), 32'd1);
    drain();

    // Underflow.
    issue(8'h00, 8'h01, 1'b0, {1'b1, 8'hFF, 1'b0}, 1'b1);
    drain();

    // Reset in the third BUSY cycle aborts the operation.
    issue(8'h55, 8'h22, 1'b0, 10'h0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_start_ready", 32'(bus.start_ready), 32'd1);
    check("midrst_done_valid",  32'(bus.done_valid),  32'd0);
    check("midrst_diff",        32'(bus.diff),        32'd0);
    check("midrst_bout",        32'(bus.bout),        32'd0);
    issue(8'h10, 8'h01, 1'b0, {1'b0, 8'h0F, 1'b0}, 1'b1);
    drain();

    // Borrow-in producing zero.
    issue(8'h80, 8'h7F, 1'b1, {1'b0, 8'h00, 1'b1}, 1'b1);
    drain();

    // Backpressure: result held, new request refused until released.
    rdy_mode = 2;
    issue(8'h5A, 8'h0F, 1'b0, {1'b0, 8'h4B, 1'b0}, 1'b1);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.done_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!bus.done_valid) timeout("bp_done_wait");
    end
    bus.start_valid = 1'b1;
    bus.a           = 8'h01;
    bus.b           = 8'h02;
    bus.bin         = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_done_valid",  32'(bus.done_valid),  32'd1);
      check("bp_diff",        32'(bus.diff),        32'h4B);
      check("bp_bout",        32'(bus.bout),        32'd0);
      check("bp_start_ready", 32'(bus.start_ready), 32'd0);
    end
    @(negedge clk);
    rdy_mode = 0;
    @(posedge clk);
    #1;
    check("bp_release_done_valid", 32'(bus.done_valid), 32'd1);
    @(posedge clk);
    #1;
    check("bp_idle_done_valid",  32'(bus.done_valid),  32'd0);
    check("bp_idle_start_ready", 32'(bus.start_ready), 32'd1);
    @(posedge clk);
    exp_q.push_back({1'b1, 8'hFF, 1'b0});
    n_push++;
    #1;
    check("bp_new_accepted", 32'(bus.start_ready), 32'd0);
    bus.start_valid = 1'b0;
    drain();

    // Random traffic with random consumer readiness.
    rdy_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rbin;
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rbin = 1'($urandom_range(0, 1));
      issue(ra, rb, rbin, model(ra, rb, rbin), 1'b1);
    end
    rdy_mode = 0;
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("result_count", 32'(n_pop), 32'(n_push));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
